// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/shift/compare/branch ops, iterative unsigned
// MULT (shift-add) and DIV (restoring) with a start/busy/done handshake.
module ula_multiciclo #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ULARes,
    output logic [WIDTH-1:0] ULAHi,
    output logic             Zero,
    output logic             DivZero
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SL   = 4'd7;
    localparam logic [3:0] OP_SR   = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BGT  = 4'd12;
    localparam logic [3:0] OP_BLT  = 4'd13;
    localparam logic [3:0] OP_BGE  = 4'd14;
    localparam logic [3:0] OP_BLE  = 4'd15;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opb;

    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic [SHAMT_W-1:0]      shamt;
    logic [WIDTH-1:0]        quick_res;
    logic                    quick_zero;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx;
    logic [WIDTH-1:0]   mul_lo_nx;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;

    assign xs    = X;
    assign ys    = Y;
    assign shamt = Y[SHAMT_W-1:0];

    always_comb begin
        quick_res  = '0;
        quick_zero = 1'b0;
        case (ALUOp)
            OP_ADD:  quick_res = X + Y;
            OP_SUB:  quick_res = X - Y;
            OP_AND:  quick_res = X & Y;
            OP_OR:   quick_res = X | Y;
            OP_NOT:  quick_res = ~X;
            OP_SL:   quick_res = X << shamt;
            OP_SR:   quick_res = X >> shamt;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, (xs < ys)};
            OP_BEQ:  quick_zero = (X == Y);
            OP_BNE:  quick_zero = (X != Y);
            OP_BGT:  quick_zero = (xs > ys);
            OP_BLT:  quick_zero = (xs < ys);
            OP_BGE:  quick_zero = (xs >= ys);
            OP_BLE:  quick_zero = (xs <= ys);
            default: quick_res = '0;
        endcase
        // Branch ops report their condition on Zero; everything else flags a zero result.
        if (ALUOp < OP_BEQ)
            quick_zero = (quick_res == '0);
    end

    // One shift-add step: {acc_hi, acc_lo} holds partial product and remaining multiplier bits.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

    // One restoring step: acc_hi is the remainder, acc_lo shifts dividend out and quotient in.
    always_comb begin
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb};
        if (!div_diff[WIDTH]) begin
            rem_nx = div_diff[WIDTH-1:0];
            quo_nx = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = div_sh[WIDTH-1:0];
            quo_nx = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ULARes  <= '0;
            ULAHi   <= '0;
            Zero    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (ALUOp == OP_MULT) begin
                            acc_hi <= '0;
                            acc_lo <= X;
                            opb    <= Y;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= MUL;
                        end else if (ALUOp == OP_DIV && Y != '0) begin
                            acc_hi <= '0;
                            acc_lo <= X;
                            opb    <= Y;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= DIV;
                        end else if (ALUOp == OP_DIV) begin
                            ULARes  <= '1;
                            ULAHi   <= X;
                            Zero    <= 1'b0;
                            DivZero <= 1'b1;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            ULARes  <= quick_res;
                            ULAHi   <= '0;
                            Zero    <= quick_zero;
                            DivZero <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_nx;
                    acc_lo <= mul_lo_nx;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        ULARes  <= mul_lo_nx;
                        ULAHi   <= mul_hi_nx;
                        Zero    <= (mul_lo_nx == '0);
                        DivZero <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DIV: begin
                    acc_hi <= rem_nx;
                    acc_lo <= quo_nx;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        ULARes  <= quo_nx;
                        ULAHi   <= rem_nx;
                        Zero    <= (quo_nx == '0);
                        DivZero <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo (WIDTH=32) with hand-computed expected values.
module tb_ula_multiciclo;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ALUOp;
    logic [31:0] X;
    logic [31:0] Y;
    logic        busy;
    logic        done;
    logic [31:0] ULARes;
    logic [31:0] ULAHi;
    logic        Zero;
    logic        DivZero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    ula_multiciclo #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(ALUOp), .X(X), .Y(Y),
        .busy(busy), .done(done), .ULARes(ULARes), .ULAHi(ULAHi),
        .Zero(Zero), .DivZero(DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; returns sampled #1 after the accepting edge (latency 1 point).
    task automatic launch(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; ALUOp = op; X = x; Y = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        nbusy = 0;
        while (!done && (cyc - t0) < 100) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
        end
        lat = done ? (cyc - t0 + 1) : -1;
    endtask

    task automatic quick(input string tag, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic ez);
        launch(op, x, y);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_res"}, ULARes, er);
        chk({tag, "_hi"}, ULAHi, 0);
        chk({tag, "_zero"}, Zero, ez);
        chk({tag, "_divzero"}, DivZero, 0);
    endtask

    initial begin
        int lat;
        int nb;
        int extra;

        rst_n = 1'b0; start = 1'b0; ALUOp = 4'd0; X = '0; Y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", ULARes, 0);
        chk("rst_hi", ULAHi, 0);
        chk("rst_zero", Zero, 0);
        chk("rst_divzero", DivZero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        quick("add", 4'd0, 32'd22, 32'd108, 32'd130, 1'b0);
        @(posedge clk); #1;
        chk("add_done_drop", done, 0);
        quick("sub", 4'd1, 32'd50, 32'd50, 32'd0, 1'b1);
        quick("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        quick("and", 4'd4, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 1'b0);
        quick("or", 4'd5, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0);
        quick("not", 4'd6, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        quick("sl", 4'd7, 32'd22, 32'd1, 32'd44, 1'b0);
        quick("sl_by0", 4'd7, 32'h1234, 32'h20, 32'h1234, 1'b0);
        quick("sr", 4'd8, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
        quick("slt", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        quick("slt_false", 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        quick("beq", 4'd10, 32'd7, 32'd7, 32'd0, 1'b1);
        quick("bne", 4'd11, 32'd7, 32'd7, 32'd0, 1'b0);
        quick("bgt", 4'd12, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        quick("blt", 4'd13, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        quick("bge", 4'd14, 32'd50, 32'd50, 32'd0, 1'b1);
        quick("ble", 4'd15, 32'd51, 32'd50, 32'd0, 1'b0);

        // MULT 22*108: outputs hold previous result while iterating
        launch(4'd2, 32'd22, 32'd108);
        chk("mul_busy", busy, 1);
        chk("mul_hold_res", ULARes, 0);
        chk("mul_early_done", done, 0);
        wait_done(lat, nb);
        chk("mul_lat", lat, 33);
        chk("mul_busy_cycles", nb, 32);
        chk("mul_lo", ULARes, 32'd2376);
        chk("mul_hi", ULAHi, 0);
        chk("mul_busy_end", busy, 0);

        launch(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_done(lat, nb);
        chk("mul2_lat", lat, 33);
        chk("mul2_lo", ULARes, 32'hFFFF_FFFE);
        chk("mul2_hi", ULAHi, 32'd1);

        launch(4'd3, 32'd108, 32'd22);
        wait_done(lat, nb);
        chk("div_lat", lat, 33);
        chk("div_quo", ULARes, 32'd4);
        chk("div_rem", ULAHi, 32'd20);
        chk("div_divzero", DivZero, 0);

        launch(4'd3, 32'd22, 32'd0);
        chk("div0_done", done, 1);
        chk("div0_res", ULARes, 32'hFFFF_FFFF);
        chk("div0_hi", ULAHi, 32'd22);
        chk("div0_flag", DivZero, 1);
        chk("div0_zero", Zero, 0);

        // ADD pulse with changed operands during MULT must be ignored
        launch(4'd2, 32'd7, 32'd9);
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        start = 1'b1; ALUOp = 4'd0; X = 32'd1; Y = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy", busy, 1);
        chk("ign_done", done, 0);
        wait_done(lat, nb);
        chk("ign_lat", lat, 33);
        chk("ign_res", ULARes, 32'd63);
        chk("ign_divzero_clr", DivZero, 0);
        // Start accepted in the DONE cycle
        launch(4'd0, 32'd5, 32'd6);
        chk("b2b_done", done, 1);
        chk("b2b_res", ULARes, 32'd11);
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (done) extra++; end
        chk("b2b_no_extra_done", extra, 0);

        // Reset at cycle 10 of a DIV aborts it
        launch(4'd3, 32'd108, 32'd22);
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res", ULARes, 0);
        chk("abort_hi", ULAHi, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (done) extra++; end
        chk("abort_no_done", extra, 0);

        launch(4'd2, 32'd3, 32'd4);
        wait_done(lat, nb);
        chk("post_mul_lat", lat, 33);
        chk("post_mul_res", ULARes, 32'd12);
        chk("post_mul_hi", ULAHi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
